// File: rtl/cpu_dmpu_gate.sv
// Data-side bus gate between the CPU load/store unit and the data memory bus.
// Each CPU request is held for one cycle while the MPU verdict arrives. Allowed
// requests are forwarded to memory; denied ones are answered with a fault. A
// sticky fault record (first fault wins) and a bus-timeout watchdog are kept.

module cpu_dmpu_gate #(
    parameter int unsigned TIMEOUT = 256
) (
    input  logic        clock,
    input  logic        reset,
    // CPU data request
    input  logic        cpud_request,
    input  logic        cpud_write,
    input  logic [31:0] cpud_addr,
    input  logic [31:0] cpud_wdata,
    input  logic [3:0]  cpud_wmask,
    // MPU verdict, valid in the cycle after cpud_request
    input  logic        access_deny,
    // Memory bus
    output logic        mem_request,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    // CPU response
    output logic        cpud_ack,
    output logic [31:0] cpud_rdata,
    output logic        cpud_fault,
    // Fault record
    output logic        fault_valid,
    output logic [31:0] fault_addr,
    output logic [1:0]  fault_cause,
    output logic        fault_overrun,
    input  logic        fault_clear
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StCheck = 2'd1;
    localparam logic [1:0] StWait  = 2'd2;

    localparam logic [1:0] CauseReadDeny  = 2'b01;
    localparam logic [1:0] CauseWriteDeny = 2'b10;
    localparam logic [1:0] CauseTimeout   = 2'b11;

    logic [1:0]      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic            mem_request_q, mem_request_d;
    logic            mem_write_q;
    logic [31:0]     mem_addr_q;
    logic [31:0]     mem_wdata_q;
    logic [3:0]      mem_wmask_q;
    logic            latch_en;

    logic            cpud_ack_q, cpud_ack_d;
    logic            cpud_fault_q, cpud_fault_d;
    logic [31:0]     cpud_rdata_q, cpud_rdata_d;

    logic            fault_valid_q, fault_valid_d;
    logic [31:0]     fault_addr_q;
    logic [1:0]      fault_cause_q;
    logic            fault_overrun_q, fault_overrun_d;

    logic            fault_evt;
    logic [1:0]      fault_evt_cause;
    logic            overrun_evt;
    logic            record_en;

    // Transaction FSM: next state, response pulses and watchdog counter.
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        latch_en        = 1'b0;
        mem_request_d   = 1'b0;
        cpud_ack_d      = 1'b0;
        cpud_fault_d    = 1'b0;
        cpud_rdata_d    = cpud_rdata_q;
        fault_evt       = 1'b0;
        fault_evt_cause = 2'b00;
        overrun_evt     = 1'b0;

        case (state_q)
            StIdle: begin
                // A late mem_ack after a timeout lands here and is ignored.
                if (cpud_request) begin
                    latch_en = 1'b1;
                    state_d  = StCheck;
                end
            end
            StCheck: begin
                overrun_evt = cpud_request;
                if (access_deny) begin
                    cpud_fault_d    = 1'b1;
                    fault_evt       = 1'b1;
                    fault_evt_cause = mem_write_q ? CauseWriteDeny : CauseReadDeny;
                    state_d         = StIdle;
                end else begin
                    mem_request_d = 1'b1;
                    cnt_d         = '0;
                    state_d       = StWait;
                end
            end
            StWait: begin
                overrun_evt = cpud_request;
                // Ack takes priority over a timeout on the same cycle.
                if (mem_ack) begin
                    cpud_ack_d   = 1'b1;
                    cpud_rdata_d = mem_write_q ? 32'h0 : mem_rdata;
                    state_d      = StIdle;
                end else if (cnt_q == CntLast) begin
                    cpud_fault_d    = 1'b1;
                    fault_evt       = 1'b1;
                    fault_evt_cause = CauseTimeout;
                    state_d         = StIdle;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Fault record: first fault is kept unless cleared in the same cycle.
    always_comb begin
        record_en       = fault_evt && (!fault_valid_q || fault_clear);
        fault_valid_d   = fault_valid_q;
        fault_overrun_d = fault_overrun_q;
        if (fault_clear) begin
            fault_valid_d   = 1'b0;
            fault_overrun_d = 1'b0;
        end
        if (fault_evt) begin
            fault_valid_d = 1'b1;
        end
        if (overrun_evt) begin
            fault_overrun_d = 1'b1;
        end
    end

    // FSM state, watchdog counter and single-cycle pulse registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            mem_request_q <= 1'b0;
            cpud_ack_q    <= 1'b0;
            cpud_fault_q  <= 1'b0;
            cpud_rdata_q  <= 32'h0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            mem_request_q <= mem_request_d;
            cpud_ack_q    <= cpud_ack_d;
            cpud_fault_q  <= cpud_fault_d;
            cpud_rdata_q  <= cpud_rdata_d;
        end
    end

    // Request latch; these registers also drive the memory bus directly.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem_write_q <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
            mem_wmask_q <= 4'h0;
        end else if (latch_en) begin
            mem_write_q <= cpud_write;
            mem_addr_q  <= cpud_addr;
            mem_wdata_q <= cpud_wdata;
            mem_wmask_q <= cpud_wmask;
        end
    end

    // Sticky fault record and overrun flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fault_valid_q   <= 1'b0;
            fault_addr_q    <= 32'h0;
            fault_cause_q   <= 2'b00;
            fault_overrun_q <= 1'b0;
        end else begin
            fault_valid_q   <= fault_valid_d;
            fault_overrun_q <= fault_overrun_d;
            if (record_en) begin
                fault_addr_q  <= mem_addr_q;
                fault_cause_q <= fault_evt_cause;
            end
        end
    end

    assign mem_request   = mem_request_q;
    assign mem_write     = mem_write_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;
    assign mem_wmask     = mem_wmask_q;
    assign cpud_ack      = cpud_ack_q;
    assign cpud_rdata    = cpud_rdata_q;
    assign cpud_fault    = cpud_fault_q;
    assign fault_valid   = fault_valid_q;
    assign fault_addr    = fault_addr_q;
    assign fault_cause   = fault_cause_q;
    assign fault_overrun = fault_overrun_q;

`ifndef SYNTHESIS
    // Structural invariants of the response and bus pulses.
    always_ff @(posedge clock) begin
        if (!reset) begin
            assert (!(cpud_ack_q && cpud_fault_q));
            assert (!mem_request_q || state_q == StWait);
            assert (state_q != StWait || cnt_q <= CntLast);
        end
    end
`endif

endmodule

// File: tb/tb_cpu_dmpu_gate.sv
// Self-checking bench for cpu_dmpu_gate: table-driven transactions plus hand
// sequences for overrun, clear/fault collision, back-to-back and reset in WAIT.
// Expected bus requests and CPU responses go into queues and are popped by a
// negedge monitor as the DUT produces them.

module tb_cpu_dmpu_gate;

    localparam int unsigned TO = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        cpud_request, cpud_write;
    logic [31:0] cpud_addr, cpud_wdata;
    logic [3:0]  cpud_wmask;
    logic        access_deny;
    logic        mem_request, mem_write;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        cpud_ack, cpud_fault;
    logic [31:0] cpud_rdata;
    logic        fault_valid, fault_overrun, fault_clear;
    logic [31:0] fault_addr;
    logic [1:0]  fault_cause;

    cpu_dmpu_gate #(.TIMEOUT(TO)) dut (
        .clock        (clock),
        .reset        (reset),
        .cpud_request (cpud_request),
        .cpud_write   (cpud_write),
        .cpud_addr    (cpud_addr),
        .cpud_wdata   (cpud_wdata),
        .cpud_wmask   (cpud_wmask),
        .access_deny  (access_deny),
        .mem_request  (mem_request),
        .mem_write    (mem_write),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_wmask    (mem_wmask),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .cpud_ack     (cpud_ack),
        .cpud_rdata   (cpud_rdata),
        .cpud_fault   (cpud_fault),
        .fault_valid  (fault_valid),
        .fault_addr   (fault_addr),
        .fault_cause  (fault_cause),
        .fault_overrun(fault_overrun),
        .fault_clear  (fault_clear)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          cyc;
        logic        is_fault;
        logic [31:0] rdata;
    } resp_t;

    typedef struct {
        int          cyc;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } mreq_t;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic        deny;
        int          ack_dly;   // cycle of mem_ack relative to request, -1 = none
        logic [31:0] rdata;
        logic        clear;     // pulse fault_clear before the request
        logic        exp_fault;
        int          exp_lat;
        logic [31:0] exp_rdata;
        logic        exp_fv;
        logic [31:0] exp_faddr;
        logic [1:0]  exp_fcause;
    } vec_t;

    resp_t resp_q[$];
    mreq_t mreq_q[$];
    resp_t mon_r;
    mreq_t mon_m;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Response and bus-request monitor, sampled mid-cycle.
    always @(negedge clock) begin
        if (reset === 1'b0) begin
            check("ack_fault_exclusive", 32'(cpud_ack & cpud_fault), 32'd0);
            if (cpud_ack || cpud_fault) begin
                if (resp_q.size() == 0) begin
                    check("unexpected_response", 32'(cpud_ack | cpud_fault), 32'd0);
                end else begin
                    mon_r = resp_q.pop_front();
                    check("resp_cycle", 32'(cyc), 32'(mon_r.cyc));
                    check("resp_is_fault", 32'(cpud_fault), 32'(mon_r.is_fault));
                    if (!mon_r.is_fault) check("cpud_rdata", cpud_rdata, mon_r.rdata);
                end
            end
            if (mem_request) begin
                if (mreq_q.size() == 0) begin
                    check("unexpected_mem_request", 32'(mem_request), 32'd0);
                end else begin
                    mon_m = mreq_q.pop_front();
                    check("mreq_cycle", 32'(cyc), 32'(mon_m.cyc));
                    check("mem_write", 32'(mem_write), 32'(mon_m.wr));
                    check("mem_addr", mem_addr, mon_m.addr);
                    check("mem_wdata", mem_wdata, mon_m.wdata);
                    check("mem_wmask", 32'(mem_wmask), 32'(mon_m.wmask));
                end
            end
        end
    end

    // Drive one cycle of inputs and advance to just after the next edge.
    task automatic step(input logic req, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] wmask,
                        input logic deny, input logic ack, input logic [31:0] rdata);
        cpud_request = req;
        cpud_write   = wr;
        cpud_addr    = addr;
        cpud_wdata   = wdata;
        cpud_wmask   = wmask;
        access_deny  = deny;
        mem_ack      = ack;
        mem_rdata    = rdata;
        @(posedge clock);
        #1;
        cpud_request = 1'b0;
        mem_ack      = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic drain(input string name);
        check({name, "_resp_pending"}, 32'(resp_q.size()), 32'd0);
        check({name, "_mreq_pending"}, 32'(mreq_q.size()), 32'd0);
        resp_q.delete();
        mreq_q.delete();
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_ctrl"}, 32'({mem_request, cpud_ack, cpud_fault, fault_valid,
                                    fault_overrun, mem_write}), 32'd0);
        check({name, "_mem_addr"}, mem_addr, 32'h0);
        check({name, "_mem_wdata"}, mem_wdata, 32'h0);
        check({name, "_mem_wmask"}, 32'(mem_wmask), 32'd0);
        check({name, "_cpud_rdata"}, cpud_rdata, 32'h0);
        check({name, "_fault_addr"}, fault_addr, 32'h0);
        check({name, "_fault_cause"}, 32'(fault_cause), 32'd0);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int r;
        int n;
        if (v.clear) begin
            fault_clear = 1'b1;
            idle(1);
            fault_clear = 1'b0;
            check($sformatf("v%0d_cleared_valid", idx), 32'(fault_valid), 32'd0);
        end
        r = cyc;
        if (!v.deny) mreq_q.push_back('{r + 2, v.wr, v.addr, v.wdata, v.wmask});
        resp_q.push_back('{r + v.exp_lat, v.exp_fault, v.exp_rdata});
        n = (v.ack_dly > v.exp_lat) ? v.ack_dly : v.exp_lat;
        for (int k = 0; k <= n; k++) begin
            step(k == 0, v.wr, v.addr, v.wdata, v.wmask, v.deny, k == v.ack_dly,
                 (k == v.ack_dly) ? v.rdata : 32'h0);
        end
        check($sformatf("v%0d_fault_valid", idx), 32'(fault_valid), 32'(v.exp_fv));
        if (v.exp_fv) begin
            check($sformatf("v%0d_fault_addr", idx), fault_addr, v.exp_faddr);
            check($sformatf("v%0d_fault_cause", idx), 32'(fault_cause), 32'(v.exp_fcause));
        end
        idle(2);
        drain($sformatf("v%0d", idx));
    endtask

    vec_t vecs[9];

    initial begin
        int r;
        //          wr    addr          wdata         wmask  deny ack rdata         clr
        //          fault lat exp_rdata     fv    faddr         cause
        vecs[0] = '{1'b0, 32'h0000_1234, 32'h0,        4'h0, 1'b0, 5, 32'hDEAD_BEEF, 1'b0,
                    1'b0, 6, 32'hDEAD_BEEF, 1'b0, 32'h0,         2'b00};
        vecs[1] = '{1'b1, 32'h8000_0010, 32'h0000_55AA, 4'h3, 1'b1, -1, 32'h0,       1'b0,
                    1'b1, 2, 32'h0,         1'b1, 32'h8000_0010, 2'b10};
        vecs[2] = '{1'b0, 32'h0000_0100, 32'h0,        4'h0, 1'b1, -1, 32'h0,        1'b1,
                    1'b1, 2, 32'h0,         1'b1, 32'h0000_0100, 2'b01};
        vecs[3] = '{1'b0, 32'h0000_0200, 32'h0,        4'h0, 1'b1, -1, 32'h0,        1'b0,
                    1'b1, 2, 32'h0,         1'b1, 32'h0000_0100, 2'b01};
        vecs[4] = '{1'b1, 32'h0000_2000, 32'hCAFE_F00D, 4'hF, 1'b0, 3, 32'h1234_5678, 1'b1,
                    1'b0, 4, 32'h0,         1'b0, 32'h0,         2'b00};
        // Timeout after 4 WAIT cycles; the late ack at +8 must be ignored.
        vecs[5] = '{1'b0, 32'h0000_4000, 32'h0,        4'h0, 1'b0, 8, 32'h1111_1111, 1'b0,
                    1'b1, 6, 32'h0,         1'b1, 32'h0000_4000, 2'b11};
        vecs[6] = '{1'b0, 32'h0000_0050, 32'h0,        4'h0, 1'b0, 2, 32'hA5A5_A5A5, 1'b1,
                    1'b0, 3, 32'hA5A5_A5A5, 1'b0, 32'h0,         2'b00};
        vecs[7] = '{1'b1, 32'h0000_0060, 32'h0000_0001, 4'h4, 1'b1, -1, 32'h0,       1'b0,
                    1'b1, 2, 32'h0,         1'b1, 32'h0000_0060, 2'b10};
        vecs[8] = '{1'b0, 32'h0000_00B0, 32'h0,        4'h0, 1'b0, 3, 32'h600D_F00D, 1'b0,
                    1'b0, 4, 32'h600D_F00D, 1'b0, 32'h0,         2'b00};

        reset = 1'b1;
        fault_clear = 1'b0;
        cpud_request = 1'b0; cpud_write = 1'b0; cpud_addr = 32'h0; cpud_wdata = 32'h0;
        cpud_wmask = 4'h0; access_deny = 1'b0; mem_ack = 1'b0; mem_rdata = 32'h0;
        repeat (2) @(posedge clock);
        #1;
        check_all_zero("reset");
        reset = 1'b0;
        idle(1);

        for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

        // Clear and a new deny fault on the same edge: new fault is recorded.
        r = cyc;
        resp_q.push_back('{r + 2, 1'b1, 32'h0});
        step(1'b1, 1'b0, 32'h70, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0);
        fault_clear = 1'b1;
        step(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0);
        fault_clear = 1'b0;
        idle(2);
        check("clr_collide_valid", 32'(fault_valid), 32'd1);
        check("clr_collide_addr", fault_addr, 32'h70);
        check("clr_collide_cause", 32'(fault_cause), 32'd1);
        drain("clr_collide");

        // Back-to-back: second request in the cpud_fault cycle is accepted.
        r = cyc;
        resp_q.push_back('{r + 2, 1'b1, 32'h0});
        mreq_q.push_back('{r + 4, 1'b0, 32'h90, 32'h0, 4'h0});
        resp_q.push_back('{r + 6, 1'b0, 32'h77});
        step(1'b1, 1'b0, 32'h80, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b0, 32'h90, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0);
        idle(2);
        step(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 32'h77);
        idle(2);
        check("b2b_overrun", 32'(fault_overrun), 32'd0);
        check("b2b_fault_addr_kept", fault_addr, 32'h70);
        drain("b2b");

        // Request during WAIT is dropped and flags overrun.
        r = cyc;
        mreq_q.push_back('{r + 2, 1'b0, 32'h300, 32'h0, 4'h0});
        resp_q.push_back('{r + 5, 1'b0, 32'h0BAD_F00D});
        step(1'b1, 1'b0, 32'h300, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0);
        idle(2);
        step(1'b1, 1'b1, 32'h999, 32'h1, 4'hF, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 32'h0BAD_F00D);
        idle(2);
        check("overrun_set", 32'(fault_overrun), 32'd1);
        check("overrun_addr_kept", mem_addr, 32'h300);
        fault_clear = 1'b1;
        idle(1);
        fault_clear = 1'b0;
        check("overrun_cleared", 32'(fault_overrun), 32'd0);
        drain("overrun");

        // Reset asserted in WAIT clears everything immediately.
        r = cyc;
        mreq_q.push_back('{r + 2, 1'b0, 32'hA0, 32'h0, 4'h0});
        step(1'b1, 1'b0, 32'hA0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0);
        idle(2);
        reset = 1'b1;
        #1;
        check_all_zero("reset_in_wait");
        #2;
        reset = 1'b0;
        idle(3);
        drain("reset_in_wait");
        run_vec(8, vecs[8]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
